// File: rtl/ram_cmd_ctrl_if.sv
// Command/response handshake bundle between an upstream requester and ram_cmd_ctrl.
// The master modport is the requester side; the slave modport is the controller side.
interface ram_cmd_ctrl_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_cmd_ctrl.sv
// Command sequencer that owns the write/address/data pins of a small register file.
// Define RAM_VERIFY_EN to add a read-back VERIFY cycle after each write with a sticky err flag.
module ram_cmd_ctrl #(
  parameter int unsigned   AW     = 4,
  parameter int unsigned   DW     = 8,
  parameter logic [DW-1:0] CLRVAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_cmd_ctrl_if.slave bus,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          err
);

  localparam logic [AW:0] SweepEnd = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CntOne   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StClear, StVerify} state_e;

  state_e        state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [AW:0]   cnt_q, cnt_d;
`ifdef RAM_VERIFY_EN
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef RAM_VERIFY_EN
    err_d       = err_q;
`endif
    if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          case (bus.cmd_op)
            2'b01: begin
              state_d    = StWrite;
              ram_we_d   = 1'b1;
              ram_addr_d = bus.cmd_addr;
              ram_din_d  = bus.cmd_data;
            end
            2'b10: begin
              state_d    = StRead;
              ram_addr_d = bus.cmd_addr;
            end
            2'b11: begin
              state_d    = StClear;
              ram_we_d   = 1'b1;
              ram_addr_d = '0;
              ram_din_d  = CLRVAL;
              cnt_d      = CntOne;
            end
            default: ;  // NOP and unknown encodings
          endcase
        end
      end
`ifdef RAM_VERIFY_EN
      StWrite: state_d = StVerify;
      StVerify: begin
        // ram_din_q still holds the written value; ram_addr_q is unchanged
        if (ram_dout != ram_din_q) err_d = 1'b1;
        state_d = StIdle;
      end
`else
      StWrite: state_d = StIdle;
`endif
      StRead: begin
        rsp_data_d  = ram_dout;
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      StClear: begin
        // Counter is one bit wider than the address so the end of sweep is unambiguous
        if (cnt_q == SweepEnd) begin
          state_d = StIdle;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = cnt_q[AW-1:0];
          cnt_d      = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle) && !rsp_valid_d;
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef RAM_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = busy_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_din       = ram_din_q;

endmodule
